// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// States, response codes, reset values and the PC alignment helper.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_AR   = 2'd0,
        S_R    = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] PC_RESET  = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    // Instructions are word aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// AXI-lite-style read channel (AR + R) between the fetch unit and instruction memory.
// The master side issues addresses and accepts data; the slave side is the memory.
interface ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rready;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time and holds it
// on inst/inst_valid until downstream commits, then continues from dnpc.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET)
) (
    input  logic              clk,
    input  logic              rst_n,
    ifu_fetch_if.master       ifu,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic [ADDR_W-1:0] dnpc,
    output logic              fetch_err
);

    ifu_state_e state;
    ifu_state_e next_state;
    logic       arvalid_q;
    logic       rready_q;

    assign ifu.arvalid = arvalid_q;
    assign ifu.araddr  = pc;
    assign ifu.rready  = rready_q;

    // The AR handshake only counts once arvalid is actually on the bus.
    always_comb begin
        next_state = state;
        case (state)
            S_AR: begin
                if (arvalid_q && ifu.arready) begin
                    next_state = S_R;
                end
            end
            S_R: begin
                if (ifu.rvalid) begin
                    next_state = (ifu.rresp == RESP_OKAY) ? S_HOLD : S_ERR;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    next_state = is_misaligned(dnpc[1:0]) ? S_ERR : S_AR;
                end
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: begin
                next_state = S_ERR;
            end
        endcase
    end

    // Handshake outputs are registered so no bus input reaches an output combinationally;
    // arvalid therefore rises one cycle after entering S_AR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_AR;
            pc         <= RESET_PC;
            inst       <= DATA_W'(INST_NOP);
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state     <= next_state;
            arvalid_q <= (state == S_AR) && (next_state == S_AR);
            rready_q  <= (next_state == S_R);
            case (state)
                S_R: begin
                    if (ifu.rvalid) begin
                        if (ifu.rresp == RESP_OKAY) begin
                            inst       <= ifu.rdata;
                            inst_valid <= 1'b1;
                        end else begin
                            fetch_err  <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= dnpc;
                        if (is_misaligned(dnpc[1:0])) begin
                            fetch_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: nominal fetch, bus stalls, downstream stalls,
// access fault, misaligned next PC and reset in the middle of a read.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] dnpc;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifu       (bus.master),
        .pc        (pc),
        .inst      (inst),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .dnpc      (dnpc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ar, input logic rv, input logic [31:0] rd,
                                 input logic [1:0] rsp);
        bus.arready = ar;
        bus.rvalid  = rv;
        bus.rdata   = rd;
        bus.rresp   = rsp;
    endtask

    task automatic commit(input logic [31:0] next_pc);
        dnpc       = next_pc;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        dnpc       = 32'h0;
        applyStimulus(1'b1, 1'b1, 32'h0010_0093, 2'b00);
        step();
        step();

        // Reset state
        checkOutput("rst_arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("rst_rready", 32'(bus.rready), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", inst, 32'h0000_0013);
        checkOutput("rst_pc", pc, 32'h8000_0000);
        checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);

        // 1: first fetch with memory always ready
        rst_n = 1'b1;
        step();
        checkOutput("t1_arvalid", 32'(bus.arvalid), 32'd1);
        checkOutput("t1_araddr", bus.araddr, 32'h8000_0000);
        step();
        checkOutput("t1_rready", 32'(bus.rready), 32'd1);
        checkOutput("t1_arvalid_drop", 32'(bus.arvalid), 32'd0);
        step();
        checkOutput("t1_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("t1_inst", inst, 32'h0010_0093);
        checkOutput("t1_pc", pc, 32'h8000_0000);

        // 2: commit to pc+4, minimum 3-cycle turnaround
        applyStimulus(1'b1, 1'b1, 32'h0020_0113, 2'b00);
        commit(32'h8000_0004);
        checkOutput("t2_inst_valid_low", 32'(inst_valid), 32'd0);
        checkOutput("t2_pc", pc, 32'h8000_0004);
        step();
        checkOutput("t2_arvalid", 32'(bus.arvalid), 32'd1);
        checkOutput("t2_araddr", bus.araddr, 32'h8000_0004);
        step();
        checkOutput("t2_inst_valid_gap", 32'(inst_valid), 32'd0);
        step();
        checkOutput("t2_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("t2_inst", inst, 32'h0020_0113);

        // 3: arready stalled 5 cycles, rvalid delayed 4 cycles
        applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00);
        commit(32'h8000_0008);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t3_arvalid_hold", 32'(bus.arvalid), 32'd1);
            checkOutput("t3_araddr_hold", bus.araddr, 32'h8000_0008);
        end
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        checkOutput("t3_rready", 32'(bus.rready), 32'd1);
        checkOutput("t3_arvalid_drop", 32'(bus.arvalid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t3_rready_hold", 32'(bus.rready), 32'd1);
            checkOutput("t3_no_capture", inst, 32'h0020_0113);
            checkOutput("t3_inst_valid_low", 32'(inst_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'h0030_0193, 2'b00);
        step();
        bus.rvalid = 1'b0;
        checkOutput("t3_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("t3_inst", inst, 32'h0030_0193);
        checkOutput("t3_pc", pc, 32'h8000_0008);

        // 4: downstream stalls 10 cycles
        applyStimulus(1'b1, 1'b1, 32'h1111_1111, 2'b00);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("t4_no_ar", 32'(bus.arvalid), 32'd0);
            checkOutput("t4_inst_stable", inst, 32'h0030_0193);
            checkOutput("t4_pc_stable", pc, 32'h8000_0008);
            checkOutput("t4_inst_valid", 32'(inst_valid), 32'd1);
        end

        // 5: access fault, then reset recovers
        applyStimulus(1'b1, 1'b1, 32'h2222_2222, 2'b10);
        commit(32'h8000_000C);
        step();
        step();
        step();
        checkOutput("t5_fetch_err", 32'(fetch_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t5_arvalid_dead", 32'(bus.arvalid), 32'd0);
            checkOutput("t5_rready_dead", 32'(bus.rready), 32'd0);
            checkOutput("t5_inst_valid_dead", 32'(inst_valid), 32'd0);
        end
        rst_n = 1'b0;
        step();
        checkOutput("t5_err_cleared", 32'(fetch_err), 32'd0);
        checkOutput("t5_pc_reset", pc, 32'h8000_0000);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h0010_0093, 2'b00);
        step();
        step();
        step();
        checkOutput("t5_refetch_valid", 32'(inst_valid), 32'd1);
        checkOutput("t5_refetch_inst", inst, 32'h0010_0093);
        checkOutput("t5_refetch_pc", pc, 32'h8000_0000);

        // 6: misaligned next PC, then reset during S_R drops the late beat
        commit(32'h8000_0006);
        checkOutput("t6_misalign_err", 32'(fetch_err), 32'd1);
        checkOutput("t6_inst_valid", 32'(inst_valid), 32'd0);
        step();
        checkOutput("t6_arvalid_dead", 32'(bus.arvalid), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0, 2'b00);
        step();
        step();
        checkOutput("t6_in_s_r", 32'(bus.rready), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'hBADB_ADBA, 2'b00);
        step();
        rst_n = 1'b1;
        bus.arready = 1'b0;
        step();
        checkOutput("t6_late_rready", 32'(bus.rready), 32'd0);
        checkOutput("t6_late_valid", 32'(inst_valid), 32'd0);
        checkOutput("t6_late_arvalid", 32'(bus.arvalid), 32'd1);
        step();
        checkOutput("t6_late_ignored", inst, 32'h0000_0013);
        applyStimulus(1'b1, 1'b0, 32'h0040_0213, 2'b00);
        step();
        applyStimulus(1'b0, 1'b1, 32'h0040_0213, 2'b00);
        step();
        checkOutput("t6_refetch_valid", 32'(inst_valid), 32'd1);
        checkOutput("t6_refetch_inst", inst, 32'h0040_0213);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
